// File: rtl/webshooter_pkg.sv
// Shared definitions for the web shooter front-end: fire-mode codes,
// sequencer state encoding and the burst-length helper.
package webshooter_pkg;

    typedef enum logic [2:0] {
        SWING    = 3'b000,
        RICOCHET = 3'b001,
        SPLITTER = 3'b011,
        GRENADE  = 3'b111,
        TASER    = 3'b110,
        RAPID    = 3'b100,
        TRACER   = 3'b101
    } fire_mode_e;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FIRE_HOLD   = 3'd1,
        S_FIRE_GAP    = 3'd2,
        S_REFILL_HOLD = 3'd3,
        S_REFILL_GAP  = 3'd4
    } seq_state_e;

    function automatic logic [3:0] shots_per_press(
        input logic [2:0] mode,
        input logic [3:0] burst
    );
        return (mode == RAPID) ? burst : 4'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; after reset a low sample is needed before an edge
// can be reported, so a button held through reset never fires.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic low_seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_seen_q <= 1'b0;
        end else begin
            low_seen_q <= ~d_i;
        end
    end

    assign rise_o = d_i & low_seen_q;

endmodule

// File: rtl/web_trigger_sequencer.sv
// Button front-end for the web shooter: turns fire/refill presses into timed
// trigger/refill strobes, expands RAPID bursts and tracks shot outcomes.
module web_trigger_sequencer
    import webshooter_pkg::*;
#(
    parameter int HOLD_CYCLES   = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int REFILL_CYCLES = 2,
    parameter int BURST_LEN     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_fire,
    input  logic       btn_refill,
    input  logic [2:0] mode_sel,
    input  logic [4:0] target_sel,
    input  logic       shoot,
    input  logic       not_enough,
    output logic       trigger,
    output logic       refill,
    output logic [2:0] fire_mode,
    output logic [4:0] target_cnt,
    output logic       busy,
    output logic       shot_ok,
    output logic       shot_fail,
    output logic       refill_done,
    output logic       low_resource,
    output logic [7:0] shots_fired
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAXC   = (MAX_HG > REFILL_CYCLES) ? MAX_HG : REFILL_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] REFILL_LAST = CW'(REFILL_CYCLES - 1);
    localparam logic [3:0]    BURST       = 4'(BURST_LEN);

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    burst_q;
    logic          hit_q;
    logic          trigger_q;
    logic          refill_q;
    logic [2:0]    mode_q;
    logic [4:0]    tgt_q;
    logic          busy_q;
    logic          ok_q;
    logic          fail_q;
    logic          rdone_q;
    logic          lowres_q;
    logic [7:0]    shots_q;

    logic          fire_rise;
    logic          refill_rise;
    logic          hit_d;
    logic [7:0]    shots_d;

    rise_detect u_fire_rise (
        .clk    (clk),
        .rst    (rst),
        .d_i    (btn_fire),
        .rise_o (fire_rise)
    );

    rise_detect u_refill_rise (
        .clk    (clk),
        .rst    (rst),
        .d_i    (btn_refill),
        .rise_o (refill_rise)
    );

    // The final hold cycle still counts toward the hit decision.
    assign hit_d   = hit_q | shoot;
    assign shots_d = (shots_q == 8'hFF) ? shots_q : shots_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            burst_q   <= 4'd0;
            hit_q     <= 1'b0;
            trigger_q <= 1'b0;
            refill_q  <= 1'b0;
            mode_q    <= 3'b000;
            tgt_q     <= 5'd1;
            busy_q    <= 1'b0;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
            rdone_q   <= 1'b0;
            lowres_q  <= 1'b0;
            shots_q   <= 8'd0;
        end else begin
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            rdone_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (refill_rise) begin
                        state_q  <= S_REFILL_HOLD;
                        refill_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end else if (fire_rise) begin
                        state_q   <= S_FIRE_HOLD;
                        mode_q    <= mode_sel;
                        tgt_q     <= target_sel;
                        burst_q   <= shots_per_press(mode_sel, BURST);
                        hit_q     <= 1'b0;
                        trigger_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_FIRE_HOLD: begin
                    hit_q <= hit_d;
                    if (not_enough) begin
                        lowres_q <= 1'b1;
                    end
                    if (cnt_q == HOLD_LAST) begin
                        state_q   <= S_FIRE_GAP;
                        trigger_q <= 1'b0;
                        ok_q      <= hit_d;
                        fail_q    <= ~hit_d;
                        cnt_q     <= '0;
                        if (hit_d) begin
                            shots_q <= shots_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIRE_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        // A missed shot ends the burst early.
                        if (burst_q > 4'd1 && hit_q) begin
                            state_q   <= S_FIRE_HOLD;
                            burst_q   <= burst_q - 4'd1;
                            hit_q     <= 1'b0;
                            trigger_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_REFILL_HOLD: begin
                    if (cnt_q == REFILL_LAST) begin
                        state_q  <= S_REFILL_GAP;
                        refill_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_REFILL_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        rdone_q  <= 1'b1;
                        lowres_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign trigger      = trigger_q;
    assign refill       = refill_q;
    assign fire_mode    = mode_q;
    assign target_cnt   = tgt_q;
    assign busy         = busy_q;
    assign shot_ok      = ok_q;
    assign shot_fail    = fail_q;
    assign refill_done  = rdone_q;
    assign low_resource = lowres_q;
    assign shots_fired  = shots_q;

endmodule
